// File: rtl/pipeline_if_q.sv
// ---------------------------------------------------------------------------
// pipeline_if_q -- decoupled instruction fetch stage.
//
// Issues in-order fetch requests to an instruction memory with variable
// response latency. Every request allocates a queue entry holding its PC. The
// response data fills entries in order. Decode drains the queue through a
// valid/ready handshake. A redirect (pcsrc) flushes the queue. Responses that
// are still outstanding at that point are counted and dropped when they
// arrive.
//
// Optional feature macro: IF_PERF_EN (adds saturating perf counters).
//
// Ports:
//   clk          in   clock, all state on posedge
//   reset        in   asynchronous active-low reset
//   pcsrc        in   redirect request
//   branchaddr   in   redirect target
//   imem_req     out  fetch request (memory always accepts)
//   imem_addr    out  fetch address
//   imem_rvalid  in   in-order response strobe
//   imem_rdata   in   response instruction
//   instr_valid  out  head entry filled and presented to decode
//   instr_ready  in   decode accepts
//   instr        out  head instruction
//   pc           out  head PC
//   pcplus4      out  pc + PCINC
//   perf_flushes out  [IF_PERF_EN] saturating count of redirect cycles
//   perf_stalls  out  [IF_PERF_EN] saturating count of valid && !ready cycles
// ---------------------------------------------------------------------------
module pipeline_if_q #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
  parameter int unsigned      PCINC    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcsrc,
  input  logic [WIDTH-1:0] branchaddr,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcplus4
`ifdef IF_PERF_EN
  ,
  output logic [15:0]      perf_flushes,
  output logic [15:0]      perf_stalls
`else
  // perf counter ports are absent in this build
`endif
);

  localparam int unsigned      AW      = $clog2(DEPTH);
  localparam int unsigned      CW      = AW + 1;
  localparam logic [WIDTH-1:0] PCINC_W = WIDTH'(PCINC);
  localparam logic [CW:0]      DEPTH_W = (CW + 1)'(DEPTH);

  // Saturating 16-bit increment used by the perf counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [WIDTH-1:0] r_fetch_pc;
  logic [CW-1:0]    r_drop_cnt;
  logic [AW-1:0]    r_head;
  logic [CW-1:0]    r_count;     // allocated entries
  logic [CW-1:0]    r_filled;    // filled entries, always contiguous from head
  logic [WIDTH-1:0] r_q_pc    [DEPTH];
  logic [WIDTH-1:0] r_q_instr [DEPTH];
  logic [WIDTH-1:0] r_pc_hold;
  logic [WIDTH-1:0] r_instr_hold;

  logic [CW-1:0]    w_unfilled;
  logic [AW-1:0]    w_tail_idx;
  logic [AW-1:0]    w_fill_idx;
  logic             w_issue;
  logic             w_rsp_drop;
  logic             w_rsp_fill;
  logic             w_rsp_used;
  logic             w_xfer;

  // Queue bookkeeping and the handshake/issue decisions.
  always_comb begin
    w_unfilled = r_count - r_filled;
    w_tail_idx = r_head + r_count[AW-1:0];
    w_fill_idx = r_head + r_filled[AW-1:0];
    // Stale outstanding requests (drop_cnt) still occupy memory slots, so they
    // count against the queue depth together with the allocated entries.
    w_issue    = reset && !pcsrc &&
                 (({1'b0, r_count} + {1'b0, r_drop_cnt}) < DEPTH_W);
    w_rsp_drop = imem_rvalid && (r_drop_cnt != {CW{1'b0}});
    w_rsp_fill = imem_rvalid && (r_drop_cnt == {CW{1'b0}}) &&
                 (w_unfilled != {CW{1'b0}});
    w_rsp_used = w_rsp_drop || w_rsp_fill;
    instr_valid = (r_filled != {CW{1'b0}}) && !pcsrc;
    w_xfer     = instr_valid && instr_ready;
    imem_req   = w_issue;
    imem_addr  = r_fetch_pc;
  end

  // Head presentation; the hold registers keep pc/instr stable once empty.
  always_comb begin
    if (r_count != {CW{1'b0}}) begin
      pc    = r_q_pc[r_head];
      instr = r_q_instr[r_head];
    end else begin
      pc    = r_pc_hold;
      instr = r_instr_hold;
    end
    pcplus4 = pc + PCINC_W;
  end

  // Fetch PC, queue pointers/counts and the stale-response counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc   <= RESET_PC;
      r_drop_cnt   <= {CW{1'b0}};
      r_head       <= {AW{1'b0}};
      r_count      <= {CW{1'b0}};
      r_filled     <= {CW{1'b0}};
      r_pc_hold    <= RESET_PC;
      r_instr_hold <= {WIDTH{1'b0}};
    end else begin
      if (r_count != {CW{1'b0}}) begin
        r_pc_hold    <= r_q_pc[r_head];
        r_instr_hold <= r_q_instr[r_head];
      end
      if (pcsrc) begin
        // Every unfilled entry becomes a stale response. A response arriving
        // in this same cycle is consumed (as a fill or as a drop), so it is
        // taken off the total whichever way it was counted.
        r_fetch_pc <= branchaddr;
        r_drop_cnt <= r_drop_cnt + w_unfilled - CW'(w_rsp_used);
        r_count    <= {CW{1'b0}};
        r_filled   <= {CW{1'b0}};
        r_head     <= {AW{1'b0}};
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + PCINC_W;
        end
        r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop);
        r_count    <= r_count + CW'(w_issue) - CW'(w_xfer);
        r_filled   <= r_filled + CW'(w_rsp_fill) - CW'(w_xfer);
        if (w_xfer) begin
          r_head <= r_head + {{(AW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Entry storage: PC written at issue, instruction written at fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_q_pc[i]    <= RESET_PC;
        r_q_instr[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_issue) begin
        r_q_pc[w_tail_idx] <= r_fetch_pc;
      end
      if (w_rsp_fill) begin
        r_q_instr[w_fill_idx] <= imem_rdata;
      end
    end
  end

`ifdef IF_PERF_EN
  logic [15:0] r_perf_flushes;
  logic [15:0] r_perf_stalls;

  // Saturating redirect and decode-stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_flushes <= 16'd0;
      r_perf_stalls  <= 16'd0;
    end else begin
      if (pcsrc) begin
        r_perf_flushes <= sat_inc16(r_perf_flushes);
      end
      if (instr_valid && !instr_ready) begin
        r_perf_stalls <= sat_inc16(r_perf_stalls);
      end
    end
  end

  assign perf_flushes = r_perf_flushes;
  assign perf_stalls  = r_perf_stalls;
`else
  // no perf counters in this build
`endif

  pipeline_if_q_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .imem_rvalid   (imem_rvalid),
    .drop_zero     (r_drop_cnt == {CW{1'b0}}),
    .unfilled_zero (w_unfilled == {CW{1'b0}})
  );

endmodule

// ---------------------------------------------------------------------------
// pipeline_if_q_chk -- protocol checker: a response strobe must always have
// either a stale request to drop or an unfilled entry to fill.
// Ports: clk, reset (active-low), imem_rvalid, drop_zero, unfilled_zero.
// ---------------------------------------------------------------------------
module pipeline_if_q_chk (
  input logic clk,
  input logic reset,
  input logic imem_rvalid,
  input logic drop_zero,
  input logic unfilled_zero
);

  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!reset)
    !(imem_rvalid && drop_zero && unfilled_zero))
    else $error("pipeline_if_q: response with nothing outstanding");

endmodule

// File: tb/tb_pipeline_if_q.sv
module tb_pipeline_if_q;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcsrc;
  logic [31:0] branchaddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcplus4;
`ifdef IF_PERF_EN
  logic [15:0] perf_flushes;
  logic [15:0] perf_stalls;
`endif

  always #5 clk = ~clk;

  pipeline_if_q dut (
    .clk         (clk),
    .reset       (reset),
    .pcsrc       (pcsrc),
    .branchaddr  (branchaddr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .pcplus4     (pcplus4)
`ifdef IF_PERF_EN
    ,
    .perf_flushes(perf_flushes),
    .perf_stalls (perf_stalls)
`endif
  );

  // ---- reference model: queue of fetched entries, in-flight list ----------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          filled;
  } ent_t;
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  ent_t        mq[$];
  bit          inflight[$];    // 1 = belongs to current queue, 0 = stale
  logic [31:0] m_fetch_pc;
  logic [31:0] m_hold_pc;
  int          m_flush, m_stall;

  rsp_t        memq[$];
  int          last_due;
  int          cyc;

  int          lat_lo, lat_hi, ready_mode, pcsrc_pct;
  bit          force_pcsrc;
  logic [31:0] force_target;

  int          n_vec, n_err;
  int          n_req, first_valid_cyc;
  bit          track, got_req, got_valid;
  logic [31:0] trk_req_addr, trk_valid_pc;
  logic [31:0] addr_log[$];
  int          smp_flush, smp_stall;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (inflight[i]) if (!inflight[i]) n++;
    return n;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; pcsrc = 1'b0; branchaddr = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b1;
    memq.delete(); mq.delete(); inflight.delete();
    m_fetch_pc = 32'd0; m_hold_pc = 32'd0; m_flush = 0; m_stall = 0;
    #1;
    chk_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk_eq("rst_instr", instr, 32'd0);
    chk_eq("rst_pc", pc, 32'd0);
    chk_eq("rst_pcplus4", pcplus4, 32'd4);
`ifdef IF_PERF_EN
    chk_eq("rst_perf_flushes", {16'd0, perf_flushes}, 32'd0);
    chk_eq("rst_perf_stalls", {16'd0, perf_stalls}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    cyc = 1; last_due = 0; first_valid_cyc = -1;
  endtask

  task automatic do_cycle();
    bit          e_req, e_valid, xfer, live;
    logic [31:0] e_pc;
    int          due;
    @(negedge clk);
    reset = 1'b1;
    case (ready_mode)
      0:       instr_ready = 1'b1;
      1:       instr_ready = 1'b0;
      default: instr_ready = 1'($urandom_range(0, 1));
    endcase
    if (force_pcsrc) begin
      pcsrc = 1'b1; branchaddr = force_target;
    end else if ($urandom_range(0, 99) < pcsrc_pct) begin
      pcsrc = 1'b1;
      if ($urandom_range(0, 3) == 0) branchaddr = 32'hFFFF_FFF0 | ($urandom_range(0, 3) * 4);
      else                           branchaddr = $urandom & 32'h0000_FFFC;
    end else begin
      pcsrc = 1'b0; branchaddr = $urandom;
    end
    if (memq.size() > 0 && memq[0].due == cyc) begin
      imem_rvalid = 1'b1; imem_rdata = memq[0].data; memq.pop_front();
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    e_req   = !pcsrc && (mq.size() + stale_cnt() < D);
    e_valid = mq.size() > 0 && mq[0].filled && !pcsrc;
    e_pc    = (mq.size() > 0) ? mq[0].pc : m_hold_pc;
    chk_eq("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) chk_eq("imem_addr", imem_addr, m_fetch_pc);
    chk_eq("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
    chk_eq("pc", pc, e_pc);
    chk_eq("pcplus4", pcplus4, e_pc + 32'd4);
    if (e_valid) chk_eq("instr", instr, mq[0].data);
`ifdef IF_PERF_EN
    chk_eq("perf_flushes", {16'd0, perf_flushes}, m_flush);
    chk_eq("perf_stalls", {16'd0, perf_stalls}, m_stall);
    smp_flush = int'(perf_flushes); smp_stall = int'(perf_stalls);
`endif
    // observation bookkeeping for directed checks
    if (imem_req) begin n_req++; addr_log.push_back(imem_addr); end
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (track && imem_req && !got_req) begin got_req = 1'b1; trk_req_addr = imem_addr; end
    if (track && instr_valid && !got_valid) begin got_valid = 1'b1; trk_valid_pc = pc; end
    // advance the model to the next edge
    xfer = e_valid && instr_ready;
    if (e_valid && !instr_ready && m_stall < 65535) m_stall++;
    if (pcsrc && m_flush < 65535) m_flush++;
    if (mq.size() > 0) m_hold_pc = mq[0].pc;
    if (imem_rvalid && inflight.size() > 0) begin
      live = inflight.pop_front();
      if (live) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].filled) begin mq[i].filled = 1'b1; break; end
        end
      end
    end
    if (pcsrc) begin
      foreach (inflight[i]) inflight[i] = 1'b0;
      mq.delete();
      m_fetch_pc = branchaddr;
    end else begin
      if (xfer) void'(mq.pop_front());
      if (e_req) begin
        mq.push_back('{pc: m_fetch_pc, data: mem_data(m_fetch_pc), filled: 1'b0});
        inflight.push_back(1'b1);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    // memory environment reacts to what the DUT actually requested
    if (imem_req) begin
      due = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (due <= last_due) due = last_due + 1;
      memq.push_back('{due: due, data: mem_data(imem_addr)});
      last_due = due;
    end
    cyc++;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    force_pcsrc = 1'b1; force_target = tgt;
    track = 1'b1; got_req = 1'b0; got_valid = 1'b0;
    do_cycle();
    force_pcsrc = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; force_pcsrc = 1'b0; track = 1'b0;
    reset = 1'b0; pcsrc = 1'b0; branchaddr = 32'd0; imem_rvalid = 1'b0;
    imem_rdata = 32'd0; instr_ready = 1'b1;
    pcsrc_pct = 0; ready_mode = 0; lat_lo = 1; lat_hi = 1;

    // reset release, 1-cycle memory, decode always ready
    apply_reset(); addr_log.delete();
    repeat (8) do_cycle();
    chk_eq("first_valid_cycle", first_valid_cyc, 3);
    for (int i = 0; i < 4; i++) chk_eq("addr_seq", addr_log[i], 32'(i * 4));

    // backpressure: exactly DEPTH requests then hold
    apply_reset(); ready_mode = 1; n_req = 0;
    repeat (10) do_cycle();
    chk_eq("bp_req_count", n_req, D);
    chk_eq("bp_pc_held", pc, 32'd0);
    ready_mode = 0; addr_log.delete();
    repeat (8) do_cycle();
    chk_eq("bp_resume_addr", addr_log[0], 32'd16);

    // 3 requests in flight with 4-cycle latency, then redirect to 0x100
    apply_reset(); lat_lo = 4; lat_hi = 4;
    repeat (3) do_cycle();
    redirect(32'h0000_0100);
    repeat (14) do_cycle();
    chk_eq("redir_req_addr", trk_req_addr, 32'h0000_0100);
    chk_eq("redir_valid_pc", trk_valid_pc, 32'h0000_0100);
    track = 1'b0;

    // redirect in a cycle with a response and a would-be transfer
    apply_reset(); lat_lo = 1; lat_hi = 1;
    repeat (6) do_cycle();
    redirect(32'h0000_0200);
    repeat (8) do_cycle();
    chk_eq("same_cyc_valid_pc", trk_valid_pc, 32'h0000_0200);
    track = 1'b0;

    // PC wrap through the top of the address space
    addr_log.delete();
    redirect(32'hFFFF_FFF8);
    repeat (8) do_cycle();
    chk_eq("wrap_a0", addr_log[0], 32'hFFFF_FFF8);
    chk_eq("wrap_a1", addr_log[1], 32'hFFFF_FFFC);
    chk_eq("wrap_a2", addr_log[2], 32'h0000_0000);
    track = 1'b0;

`ifdef IF_PERF_EN
    // 5 stall cycles then 2 redirects
    apply_reset(); ready_mode = 1;
    repeat (7) do_cycle();
    redirect(32'h0000_0040);
    redirect(32'h0000_0080);
    do_cycle();
    track = 1'b0;
    chk_eq("perf_flushes_dir", smp_flush, 2);
    chk_eq("perf_stalls_dir", smp_stall, 5);
`endif

    // randomized traffic with occasional mid-operation reset
    apply_reset(); ready_mode = 2; lat_lo = 1; lat_hi = 5; pcsrc_pct = 5;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      do_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
